btn_conditioner: RTL and testbench

BTN_CONDITIONER -- requirements
Module: btn_conditioner

---
 rtl/btn_conditioner_if.sv | 29 ++
 rtl/btn_conditioner.sv | 166 ++++++++++++++++
 tb/tb_btn_conditioner.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/btn_conditioner_if.sv
// Button conditioner bundle: the 1 kHz tick, the two raw buttons and the
// conditioned outputs (debounced levels and one-cycle request pulses).
//   tick_1khz      : one-cycle strobe at 1 kHz, synchronous to the system clock
//   btn_accel_raw  : raw accelerate button, asynchronous, active-high
//   btn_decel_raw  : raw decelerate button, asynchronous, active-high
//   accel_level    : debounced accelerate level
//   decel_level    : debounced decelerate level
//   accel_pulse    : one-cycle accelerate request
//   decel_pulse    : one-cycle decelerate request
// master drives the tick and raw buttons; slave is the conditioner itself.
interface btn_conditioner_if;
    logic tick_1khz;
    logic btn_accel_raw;
    logic btn_decel_raw;
    logic accel_level;
    logic decel_level;
    logic accel_pulse;
    logic decel_pulse;

    modport master (
        output tick_1khz, btn_accel_raw, btn_decel_raw,
        input  accel_level, decel_level, accel_pulse, decel_pulse
    );

    modport slave (
        input  tick_1khz, btn_accel_raw, btn_decel_raw,
        output accel_level, decel_level, accel_pulse, decel_pulse
    );
endinterface

// File: rtl/btn_conditioner.sv
// Two-channel push-button conditioner (accelerate / decelerate).
// Each raw button is synchronised, debounced on the 1 kHz tick and fed to a
// small press / auto-repeat FSM that emits one-cycle request pulses. A
// channel's pulses are suppressed while the other channel is held.
//   clk_100mhz : sole clock
//   rst_n      : asynchronous active-low reset
//   bus        : btn_conditioner_if.slave (tick, raw buttons, levels, pulses)
// Channel index 0 is accelerate, 1 is decelerate.
module btn_conditioner #(
    parameter int unsigned DEB_TICKS    = 10,
    parameter int unsigned REPEAT_DELAY = 500,
    parameter int unsigned REPEAT_RATE  = 100
) (
    input  logic               clk_100mhz,
    input  logic               rst_n,
    btn_conditioner_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HELD   = 2'd1,
        REPEAT = 2'd2
    } state_e;

    localparam logic [16:0] DEB_K   = 17'(DEB_TICKS);
    localparam logic [16:0] DELAY_K = 17'(REPEAT_DELAY);
    localparam logic [16:0] RATE_K  = 17'(REPEAT_RATE);
    localparam bit          REPEAT_EN = (REPEAT_DELAY != 0);

    logic [1:0]  raw;
    logic [1:0]  sync1_q, sync2_q;
    logic [1:0]  level_q, level_d;
    logic [1:0]  levelDly_q;
    logic [1:0]  pulse_q, pulse_d;
    logic [15:0] debCnt_q  [2];
    logic [15:0] debCnt_d  [2];
    logic [15:0] holdCnt_q [2];
    logic [15:0] holdCnt_d [2];
    state_e      state_q   [2];
    state_e      state_d   [2];

    logic [1:0]  rise, fall, fallNow, pressHit, repeatHit;
    logic [16:0] debInc  [2];
    logic [16:0] holdInc [2];

    assign raw = {bus.btn_decel_raw, bus.btn_accel_raw};

    // Debounce and press/repeat next-state logic for both channels.
    // The release edge is detected one cycle late (from the delayed level),
    // so a repeat that lands on the very tick that drops the level is
    // dropped via fallNow: the release wins over that last repeat.
    always_comb begin
        level_d   = level_q;
        pulse_d   = '0;
        rise      = '0;
        fall      = '0;
        fallNow   = '0;
        pressHit  = '0;
        repeatHit = '0;
        for (int c = 0; c < 2; c++) begin
            debCnt_d[c]  = debCnt_q[c];
            holdCnt_d[c] = holdCnt_q[c];
            state_d[c]   = state_q[c];
            debInc[c]    = {1'b0, debCnt_q[c]} + 17'd1;
            holdInc[c]   = {1'b0, holdCnt_q[c]} + 17'd1;
        end

        for (int c = 0; c < 2; c++) begin
            if (bus.tick_1khz) begin
                if (sync2_q[c] != level_q[c]) begin
                    if (debInc[c] == DEB_K) begin
                        level_d[c]  = sync2_q[c];
                        debCnt_d[c] = '0;
                    end else begin
                        debCnt_d[c] = debInc[c][15:0];
                    end
                end else begin
                    debCnt_d[c] = '0;
                end
            end

            rise[c]    = level_q[c] & ~levelDly_q[c];
            fall[c]    = ~level_q[c] & levelDly_q[c];
            fallNow[c] = level_q[c] & ~level_d[c];

            case (state_q[c])
                IDLE: begin
                    if (rise[c]) begin
                        state_d[c]   = HELD;
                        holdCnt_d[c] = '0;
                        pressHit[c]  = 1'b1;
                    end
                end
                HELD: begin
                    if (fall[c]) begin
                        state_d[c]   = IDLE;
                        holdCnt_d[c] = '0;
                    end else if (bus.tick_1khz) begin
                        if (REPEAT_EN && holdInc[c] == DELAY_K) begin
                            state_d[c]   = REPEAT;
                            holdCnt_d[c] = '0;
                            repeatHit[c] = 1'b1;
                        end else if (holdCnt_q[c] != 16'hFFFF) begin
                            holdCnt_d[c] = holdInc[c][15:0];
                        end
                    end
                end
                REPEAT: begin
                    if (fall[c]) begin
                        state_d[c]   = IDLE;
                        holdCnt_d[c] = '0;
                    end else if (bus.tick_1khz) begin
                        if (holdInc[c] == RATE_K) begin
                            holdCnt_d[c] = '0;
                            repeatHit[c] = 1'b1;
                        end else if (holdCnt_q[c] != 16'hFFFF) begin
                            holdCnt_d[c] = holdInc[c][15:0];
                        end
                    end
                end
                default: begin
                    state_d[c]   = IDLE;
                    holdCnt_d[c] = '0;
                end
            endcase

            // Interlock: nothing fires while the other button is held down,
            // and a suppressed request is simply lost.
            pulse_d[c] = (pressHit[c] | (repeatHit[c] & ~fallNow[c]))
                         & level_q[c] & ~level_q[1 - c];
        end
    end

    // State registers: synchronisers, debounce, FSM and pulse flops.
    always_ff @(posedge clk_100mhz or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            level_q    <= '0;
            levelDly_q <= '0;
            pulse_q    <= '0;
            for (int c = 0; c < 2; c++) begin
                debCnt_q[c]  <= '0;
                holdCnt_q[c] <= '0;
                state_q[c]   <= IDLE;
            end
        end else begin
            sync1_q    <= raw;
            sync2_q    <= sync1_q;
            level_q    <= level_d;
            levelDly_q <= level_q;
            pulse_q    <= pulse_d;
            for (int c = 0; c < 2; c++) begin
                debCnt_q[c]  <= debCnt_d[c];
                holdCnt_q[c] <= holdCnt_d[c];
                state_q[c]   <= state_d[c];
            end
        end
    end

    assign bus.accel_level = level_q[0];
    assign bus.decel_level = level_q[1];
    assign bus.accel_pulse = pulse_q[0];
    assign bus.decel_pulse = pulse_q[1];

endmodule

// File: tb/tb_btn_conditioner.sv
// Self-checking bench for btn_conditioner. Instance A uses the default
// parameters; instance B uses DEB_TICKS=1 and REPEAT_DELAY=0. Ticks are
// issued every 8 clocks to keep the run short. Expected pulses (instance,
// channel, tick number, cycles after that tick) are queued by the stimulus
// and popped by an independent monitor whenever a pulse appears.
module tb_btn_conditioner;

    typedef struct {
        bit isDecel;
        int tick;
        int phase;
    } pulse_t;

    localparam int TICK_GAP = 7;

    logic clk;
    logic rst_n;
    logic tick;
    logic rawAccelA, rawDecelA, rawAccelB, rawDecelB;

    int tickNum;
    int phase;
    int total;
    int bad;
    pulse_t qA[$];
    pulse_t qB[$];

    btn_conditioner_if busA();
    btn_conditioner_if busB();

    assign busA.tick_1khz     = tick;
    assign busA.btn_accel_raw = rawAccelA;
    assign busA.btn_decel_raw = rawDecelA;
    assign busB.tick_1khz     = tick;
    assign busB.btn_accel_raw = rawAccelB;
    assign busB.btn_decel_raw = rawDecelB;

    btn_conditioner dutA (
        .clk_100mhz (clk),
        .rst_n      (rst_n),
        .bus        (busA)
    );

    btn_conditioner #(
        .DEB_TICKS    (1),
        .REPEAT_DELAY (0),
        .REPEAT_RATE  (100)
    ) dutB (
        .clk_100mhz (clk),
        .rst_n      (rst_n),
        .bus        (busB)
    );

    // 100 MHz clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Tick numbering: tickNum counts tick edges, phase counts clocks since
    // the most recent tick edge.
    always @(posedge clk) begin
        if (tick) begin
            tickNum <= tickNum + 1;
            phase   <= 0;
        end else begin
            phase   <= phase + 1;
        end
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        total++;
        if (actual != expected) begin
            bad++;
            $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
        end
    endtask

    task automatic expectPulse(input bit toB, input bit isDecel, input int tk, input int ph);
        pulse_t e;
        e.isDecel = isDecel;
        e.tick    = tk;
        e.phase   = ph;
        if (toB) qB.push_back(e);
        else     qA.push_back(e);
    endtask

    // Drive the raw buttons of one instance, then issue n ticks. Returns half
    // a cycle after the last tick edge, so levels changed by it are visible.
    task automatic applyStimulus(input bit toB, input logic a, input logic d, input int n);
        if (toB) begin
            rawAccelB = a;
            rawDecelB = d;
        end else begin
            rawAccelA = a;
            rawDecelA = d;
        end
        repeat (n) begin
            repeat (TICK_GAP) @(negedge clk);
            tick = 1'b1;
            @(negedge clk);
            tick = 1'b0;
        end
    endtask

    // Monitor: every pulse seen on either instance must match the head of
    // that instance's expectation queue; the two pulses never coincide.
    initial begin
        pulse_t e;
        forever begin
            @(negedge clk);
            if (busA.accel_pulse && busA.decel_pulse) begin
                total++;
                bad++;
                $display("[TB] FAIL A both pulses high at tick=%0d", tickNum);
            end
            if (busA.accel_pulse || busA.decel_pulse) begin
                total++;
                if (qA.size() == 0) begin
                    bad++;
                    $display("[TB] FAIL A unexpected pulse decel=%0d tick=%0d phase=%0d",
                             busA.decel_pulse, tickNum, phase);
                end else begin
                    e = qA.pop_front();
                    if (e.isDecel != busA.decel_pulse || e.tick != tickNum || e.phase != phase) begin
                        bad++;
                        $display("[TB] FAIL A pulse actual decel=%0d tick=%0d phase=%0d expected decel=%0d tick=%0d phase=%0d",
                                 busA.decel_pulse, tickNum, phase, e.isDecel, e.tick, e.phase);
                    end
                end
            end
            if (busB.accel_pulse || busB.decel_pulse) begin
                total++;
                if (qB.size() == 0) begin
                    bad++;
                    $display("[TB] FAIL B unexpected pulse decel=%0d tick=%0d phase=%0d",
                             busB.decel_pulse, tickNum, phase);
                end else begin
                    e = qB.pop_front();
                    if (e.isDecel != busB.decel_pulse || e.tick != tickNum || e.phase != phase) begin
                        bad++;
                        $display("[TB] FAIL B pulse actual decel=%0d tick=%0d phase=%0d expected decel=%0d tick=%0d phase=%0d",
                                 busB.decel_pulse, tickNum, phase, e.isDecel, e.tick, e.phase);
                    end
                end
            end
        end
    end

    // Directed scenarios.
    initial begin
        int t0;
        int t1;
        logic tog;

        total = 0;
        bad = 0;
        tickNum = 0;
        phase = 0;
        tick = 1'b0;
        rawAccelA = 1'b0;
        rawDecelA = 1'b0;
        rawAccelB = 1'b0;
        rawDecelB = 1'b0;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        checkOutput("reset outputs A",
                    int'({busA.accel_level, busA.decel_level, busA.accel_pulse, busA.decel_pulse}), 0);
        checkOutput("reset outputs B",
                    int'({busB.accel_level, busB.decel_level, busB.accel_pulse, busB.decel_pulse}), 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Short press: one press pulse after the 10-tick debounce, level high 20 ticks.
        t0 = tickNum;
        expectPulse(1'b0, 1'b0, t0 + 10, 1);
        applyStimulus(1'b0, 1'b1, 1'b0, 9);
        checkOutput("press level before debounce", int'(busA.accel_level), 0);
        applyStimulus(1'b0, 1'b1, 1'b0, 1);
        checkOutput("press level at debounce", int'(busA.accel_level), 1);
        applyStimulus(1'b0, 1'b1, 1'b0, 10);
        applyStimulus(1'b0, 1'b0, 1'b0, 9);
        checkOutput("release level before debounce", int'(busA.accel_level), 1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1);
        checkOutput("release level at debounce", int'(busA.accel_level), 0);
        checkOutput("press decel level", int'(busA.decel_level), 0);
        applyStimulus(1'b0, 1'b0, 1'b0, 3);
        checkOutput("press queue drained", qA.size(), 0);

        // Bounce shorter than the debounce window never changes the level.
        tog = 1'b1;
        for (int i = 0; i < 17; i++) begin
            applyStimulus(1'b0, tog, 1'b0, 3);
            checkOutput("glitch level", int'(busA.accel_level), 0);
            tog = ~tog;
        end
        applyStimulus(1'b0, 1'b0, 1'b0, 5);

        // Long decel hold: press, repeats at hold ticks 500/600/700, none on release.
        t0 = tickNum;
        expectPulse(1'b0, 1'b1, t0 + 10, 1);
        expectPulse(1'b0, 1'b1, t0 + 510, 0);
        expectPulse(1'b0, 1'b1, t0 + 610, 0);
        expectPulse(1'b0, 1'b1, t0 + 710, 0);
        applyStimulus(1'b0, 1'b0, 1'b1, 10);
        checkOutput("hold decel level", int'(busA.decel_level), 1);
        applyStimulus(1'b0, 1'b0, 1'b1, 790);
        applyStimulus(1'b0, 1'b0, 1'b0, 12);
        checkOutput("hold decel released", int'(busA.decel_level), 0);
        checkOutput("hold queue drained", qA.size(), 0);

        // Both buttons together: both levels high, no pulses at all.
        applyStimulus(1'b0, 1'b1, 1'b1, 10);
        checkOutput("both accel level", int'(busA.accel_level), 1);
        checkOutput("both decel level", int'(busA.decel_level), 1);
        applyStimulus(1'b0, 1'b1, 1'b1, 20);
        applyStimulus(1'b0, 1'b1, 1'b0, 15);
        checkOutput("both decel released", int'(busA.decel_level), 0);
        checkOutput("both accel still held", int'(busA.accel_level), 1);
        applyStimulus(1'b0, 1'b0, 1'b0, 12);
        checkOutput("both accel released", int'(busA.accel_level), 0);

        // Reset in the middle of a hold: everything cleared, fresh debounce after.
        t0 = tickNum;
        expectPulse(1'b0, 1'b0, t0 + 10, 1);
        applyStimulus(1'b0, 1'b1, 1'b0, 310);
        checkOutput("midhold level", int'(busA.accel_level), 1);
        rst_n = 1'b0;
        #1;
        checkOutput("midhold async clear",
                    int'({busA.accel_level, busA.decel_level, busA.accel_pulse, busA.decel_pulse}), 0);
        for (int i = 0; i < 10; i++) begin
            repeat (10) @(negedge clk);
            checkOutput("midhold outputs in reset",
                        int'({busA.accel_level, busA.decel_level, busA.accel_pulse, busA.decel_pulse}), 0);
        end
        rst_n = 1'b1;
        t1 = tickNum;
        expectPulse(1'b0, 1'b0, t1 + 10, 1);
        expectPulse(1'b0, 1'b0, t1 + 510, 0);
        applyStimulus(1'b0, 1'b1, 1'b0, 9);
        checkOutput("post-reset level before debounce", int'(busA.accel_level), 0);
        applyStimulus(1'b0, 1'b1, 1'b0, 1);
        checkOutput("post-reset level at debounce", int'(busA.accel_level), 1);
        applyStimulus(1'b0, 1'b1, 1'b0, 505);
        applyStimulus(1'b0, 1'b0, 1'b0, 12);
        checkOutput("post-reset queue drained", qA.size(), 0);

        // Instance B: single-tick debounce, auto-repeat disabled.
        t0 = tickNum;
        expectPulse(1'b1, 1'b0, t0 + 1, 1);
        applyStimulus(1'b1, 1'b1, 1'b0, 1);
        checkOutput("B level after one tick", int'(busB.accel_level), 1);
        applyStimulus(1'b1, 1'b1, 1'b0, 999);
        applyStimulus(1'b1, 1'b0, 1'b0, 3);
        checkOutput("B level released", int'(busB.accel_level), 0);
        checkOutput("B queue drained", qB.size(), 0);
        checkOutput("A queue still empty", qA.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
